// File: rtl/common_bus_arbiter.sv
// common_bus_arbiter
//   Round-robin arbiter for the 8-bit common data bus between two requesters:
//   requester 0 (microcode sequencer) and requester 1 (debug/DMA port).
//   Grants are registered and one-hot. Bus tenure is bounded by a counter
//   that forces a release when the other side is waiting, unless the owner
//   holds lock. Every handover passes through one turnaround cycle with no
//   grant, so two requesters never drive the bus at the same time.
//
// Parameters
//   MAX_TENURE      granted cycles before the owner may be preempted (1..15)
// Ports
//   clock           rising-edge clock
//   reset_n         asynchronous, active-low reset
//   req[1:0]        req[i] high: requester i wants or is still using the bus
//   lock[1:0]       lock[i] high: owner i must not be preempted
//   gnt[1:0]        registered one-hot grant, 00 when the bus is free
//   bus_busy        high whenever gnt != 00
//   owner           index of the current or most recent owner
//   tenure_expired  one-cycle pulse in the cycle after a forced preemption
module common_bus_arbiter #(
    parameter int unsigned MAX_TENURE = 4
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [1:0] req,
    input  logic [1:0] lock,
    output logic [1:0] gnt,
    output logic       bus_busy,
    output logic       owner,
    output logic       tenure_expired
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        RELEASE
    } state_t;

    state_t     cur;
    logic [3:0] tenure;
    logic       last;

    // Arbitration result, used in IDLE and RELEASE only.
    logic win_valid;
    logic win;

    always_comb begin
        win_valid = |req;
        // On a tie the side that did not own the bus last wins.
        win       = (req == 2'b11) ? ~last : req[1];
    end

    logic preempt;

    always_comb begin
        preempt = (tenure >= 4'(MAX_TENURE)) && req[~owner] && !lock[owner];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cur            <= IDLE;
            gnt            <= '0;
            bus_busy       <= 1'b0;
            owner          <= 1'b0;
            tenure_expired <= 1'b0;
            tenure         <= '0;
            last           <= 1'b1;
        end else begin
            tenure_expired <= 1'b0;
            case (cur)
                IDLE, RELEASE: begin
                    if (win_valid) begin
                        cur      <= GRANT;
                        gnt      <= win ? 2'b10 : 2'b01;
                        bus_busy <= 1'b1;
                        owner    <= win;
                        last     <= win;
                        tenure   <= 4'd1;
                    end else begin
                        cur      <= IDLE;
                        gnt      <= '0;
                        bus_busy <= 1'b0;
                    end
                end
                GRANT: begin
                    // A voluntary drop takes precedence over preemption, so
                    // tenure_expired only fires while the owner still wants
                    // the bus.
                    if (!req[owner]) begin
                        cur      <= RELEASE;
                        gnt      <= '0;
                        bus_busy <= 1'b0;
                    end else if (preempt) begin
                        cur            <= RELEASE;
                        gnt            <= '0;
                        bus_busy       <= 1'b0;
                        tenure_expired <= 1'b1;
                    end else if (tenure != 4'hF) begin
                        tenure <= tenure + 4'd1;
                    end
                end
                default: begin
                    cur      <= IDLE;
                    gnt      <= '0;
                    bus_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_common_bus_arbiter.sv
// Self-checking bench for common_bus_arbiter (MAX_TENURE = 4).
// Directed scenarios check against constants; all scenarios also keep a
// behavioural model in step, and a randomized run checks against it.
module tb_common_bus_arbiter;

    localparam int MAXT = 4;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] req = '0;
    logic [1:0] lock = '0;
    logic [1:0] gnt;
    logic       bus_busy;
    logic       owner;
    logic       tenure_expired;

    int total = 0;
    int bad = 0;

    common_bus_arbiter #(.MAX_TENURE(MAXT)) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .req            (req),
        .lock           (lock),
        .gnt            (gnt),
        .bus_busy       (bus_busy),
        .owner          (owner),
        .tenure_expired (tenure_expired)
    );

    always #5 clock = ~clock;

    // Behavioural model: who holds the bus, for how many cycles, and who
    // held it last. A free bus (idle or turnaround) arbitrates the same way.
    bit m_on;
    bit m_owner;
    bit m_last;
    int m_ten;
    bit m_exp;

    function automatic logic [1:0] m_gnt();
        if (!m_on) return 2'b00;
        return m_owner ? 2'b10 : 2'b01;
    endfunction

    task automatic model_reset();
        m_on = 0; m_owner = 0; m_last = 1; m_ten = 0; m_exp = 0;
    endtask

    task automatic model_edge(input logic [1:0] r, input logic [1:0] l);
        m_exp = 0;
        if (m_on) begin
            if (!r[m_owner]) begin
                m_on = 0;
            end else if (m_ten >= MAXT && r[!m_owner] && !l[m_owner]) begin
                m_on = 0;
                m_exp = 1;
            end else begin
                m_ten = (m_ten + 1 > 15) ? 15 : m_ten + 1;
            end
        end else if (r != 2'b00) begin
            bit w;
            w = (r == 2'b11) ? !m_last : r[1];
            m_on = 1; m_owner = w; m_last = w; m_ten = 1;
        end
    endtask

    // Advance one clock; outputs are sampled 1 time unit after the edge.
    task automatic tick();
        model_edge(req, lock);
        @(posedge clock);
        #1;
    endtask

    task automatic apply_reset();
        @(negedge clock);
        reset_n = 1'b0;
        req = '0;
        lock = '0;
        model_reset();
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL reset_gnt got=%b exp=00", gnt); end
        total++; if (bus_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus_busy); end
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL reset_owner got=%b exp=0", owner); end
        total++; if (tenure_expired !== 1'b0) begin bad++; $display("FAIL reset_exp got=%b exp=0", tenure_expired); end
    endtask

    task automatic test_single();
        apply_reset();
        tick();
        req = 2'b01;
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_grant got=%b exp=01", gnt); end
        total++; if (owner !== 1'b0) begin bad++; $display("FAIL single_owner got=%b exp=0", owner); end
        total++; if (bus_busy !== 1'b1) begin bad++; $display("FAIL single_busy got=%b exp=1", bus_busy); end
        tick(); tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL single_hold got=%b exp=01", gnt); end
        req = 2'b00;
        tick();
        total++; if (gnt !== 2'b00 || bus_busy !== 1'b0) begin bad++; $display("FAIL single_release got=%b/%b exp=00/0", gnt, bus_busy); end
        tick();
        total++; if (gnt !== 2'b00 || tenure_expired !== 1'b0) begin bad++; $display("FAIL single_idle got=%b/%b exp=00/0", gnt, tenure_expired); end
    endtask

    task automatic test_tie();
        apply_reset();
        req = 2'b11;
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL tie_first got=%b exp=01", gnt); end
        req = 2'b10;
        tick();
        total++; if (gnt !== 2'b00) begin bad++; $display("FAIL tie_turnaround got=%b exp=00", gnt); end
        tick();
        total++; if (gnt !== 2'b10 || owner !== 1'b1) begin bad++; $display("FAIL tie_second got=%b/%b exp=10/1", gnt, owner); end
        req = 2'b00;
        tick(); tick();
    endtask

    task automatic test_preempt();
        int pulses;
        apply_reset();
        req = 2'b01;
        tick();
        req = 2'b11;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++; if (gnt !== 2'b01 || tenure_expired !== 1'b0) begin bad++; $display("FAIL preempt_hold%0d got=%b/%b exp=01/0", i, gnt, tenure_expired); end
        end
        tick();
        total++; if (gnt !== 2'b00 || tenure_expired !== 1'b1) begin bad++; $display("FAIL preempt_release got=%b/%b exp=00/1", gnt, tenure_expired); end
        tick();
        total++; if (gnt !== 2'b10 || tenure_expired !== 1'b0) begin bad++; $display("FAIL preempt_handover got=%b/%b exp=10/0", gnt, tenure_expired); end
        // With req=11 held, each owner gets 4 cycles then one free cycle.
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (tenure_expired === 1'b1) pulses++;
            total++; if (gnt !== ((i % 5 < 3) ? (((i / 5) % 2 == 0) ? 2'b10 : 2'b01) : ((i % 5 == 3) ? 2'b00 : (((i / 5) % 2 == 0) ? 2'b01 : 2'b10))))
                begin bad++; $display("FAIL alternate%0d got=%b", i, gnt); end
        end
        total++; if (pulses != 4) begin bad++; $display("FAIL alternate_pulses got=%0d exp=4", pulses); end
        req = 2'b00;
        tick(); tick();
    endtask

    task automatic test_lock();
        apply_reset();
        req = 2'b10;
        tick();
        req = 2'b11;
        lock = 2'b10;
        for (int i = 0; i < 10; i++) begin
            tick();
            total++; if (gnt !== 2'b10 || tenure_expired !== 1'b0) begin bad++; $display("FAIL lock_hold%0d got=%b/%b exp=10/0", i, gnt, tenure_expired); end
        end
        lock = 2'b00;
        tick();
        total++; if (gnt !== 2'b00 || tenure_expired !== 1'b1) begin bad++; $display("FAIL lock_drop got=%b/%b exp=00/1", gnt, tenure_expired); end
        tick();
        total++; if (gnt !== 2'b01 || tenure_expired !== 1'b0) begin bad++; $display("FAIL lock_next got=%b/%b exp=01/0", gnt, tenure_expired); end
        // Voluntary drop with lock high still releases.
        req = 2'b10;
        lock = 2'b01;
        tick();
        total++; if (gnt !== 2'b00 || tenure_expired !== 1'b0) begin bad++; $display("FAIL lock_voluntary got=%b/%b exp=00/0", gnt, tenure_expired); end
        req = 2'b00;
        lock = 2'b00;
        tick(); tick();
    endtask

    task automatic test_saturation();
        apply_reset();
        req = 2'b10;
        // 17 granted cycles: a wrapping counter would read 1 and not preempt.
        for (int i = 0; i < 17; i++) begin
            tick();
            total++; if (gnt !== 2'b10 || tenure_expired !== 1'b0) begin bad++; $display("FAIL sat_hold%0d got=%b/%b exp=10/0", i, gnt, tenure_expired); end
        end
        req = 2'b11;
        tick();
        total++; if (gnt !== 2'b00 || tenure_expired !== 1'b1) begin bad++; $display("FAIL sat_preempt got=%b/%b exp=00/1", gnt, tenure_expired); end
        req = 2'b00;
        tick(); tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        req = 2'b10;
        tick(); tick();
        total++; if (gnt !== 2'b10) begin bad++; $display("FAIL mid_pre got=%b exp=10", gnt); end
        #3;
        reset_n = 1'b0;
        model_reset();
        #1;
        total++; if (gnt !== 2'b00 || owner !== 1'b0 || bus_busy !== 1'b0) begin bad++; $display("FAIL mid_async got=%b/%b/%b exp=00/0/0", gnt, owner, bus_busy); end
        req = 2'b11;
        @(negedge clock);
        reset_n = 1'b1;
        tick();
        total++; if (gnt !== 2'b01) begin bad++; $display("FAIL mid_after got=%b exp=01", gnt); end
        req = 2'b00;
        tick(); tick();
    endtask

    task automatic test_random();
        apply_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clock);
            req = 2'($urandom_range(0, 3));
            lock = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
            tick();
            total++; if (gnt !== m_gnt()) begin bad++; $display("FAIL rand_gnt%0d got=%b exp=%b", i, gnt, m_gnt()); end
            total++; if (bus_busy !== m_on) begin bad++; $display("FAIL rand_busy%0d got=%b exp=%b", i, bus_busy, m_on); end
            total++; if (owner !== m_owner) begin bad++; $display("FAIL rand_owner%0d got=%b exp=%b", i, owner, m_owner); end
            total++; if (tenure_expired !== m_exp) begin bad++; $display("FAIL rand_exp%0d got=%b exp=%b", i, tenure_expired, m_exp); end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_single();
        test_tie();
        test_preempt();
        test_lock();
        test_saturation();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
